// File: rtl/cpu_reg_write_arbiter.sv
// Round-robin arbiter for the register file write port; one registered write per cycle, grant to rf_* in 1 cycle.
// Optional CPU_REG_CLEAR_EN zeroes every register after reset (busy high meanwhile, no grants).
module cpu_reg_write_arbiter #(
  parameter int BITS = 8,
  parameter int SIZE = 16,
  parameter int REQUESTERS = 3,
  localparam int ADDRESS_BITS = $clog2(SIZE)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [REQUESTERS-1:0]              req_valid,
  input  logic [REQUESTERS*ADDRESS_BITS-1:0] req_addr,
  input  logic [REQUESTERS*BITS-1:0]         req_data,
  output logic [REQUESTERS-1:0]              req_ready,
  output logic                               rf_wr,
  output logic [ADDRESS_BITS-1:0]            rf_addr_write,
  output logic [BITS-1:0]                    rf_data_write,
  output logic                               busy
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic                    rf_wr_q, rf_wr_d;
  logic [ADDRESS_BITS-1:0] rf_addr_q, rf_addr_d;
  logic [BITS-1:0]         rf_data_q, rf_data_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;

  logic                    arb_en;
  logic                    gnt_vld;
  logic                    gnt_fire;
  logic [PTR_W-1:0]        gnt_idx;
  logic [ADDRESS_BITS-1:0] gnt_addr;
  logic [BITS-1:0]         gnt_data;
  int                      scan_idx;

`ifdef CPU_REG_CLEAR_EN
  localparam int CNT_W = ADDRESS_BITS + 1;

  typedef enum logic {
    ST_CLEAR,
    ST_ARB
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  assign arb_en = en && !rst && (state_q == ST_ARB);
`else
  assign arb_en = en && !rst;
`endif

  // First valid source at or after ptr, wrapping modulo REQUESTERS.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_data = '0;
    scan_idx = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= REQUESTERS) begin
        scan_idx = scan_idx - REQUESTERS;
      end
      if (!gnt_vld && req_valid[scan_idx]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = PTR_W'(scan_idx);
        gnt_addr = req_addr[scan_idx*ADDRESS_BITS +: ADDRESS_BITS];
        gnt_data = req_data[scan_idx*BITS +: BITS];
      end
    end
  end

  assign gnt_fire = arb_en && gnt_vld;

  always_comb begin
    req_ready = '0;
    if (gnt_fire) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    rf_wr_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    ptr_d     = ptr_q;
`ifdef CPU_REG_CLEAR_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
`endif

    if (gnt_fire) begin
      rf_wr_d   = 1'b1;
      rf_addr_d = gnt_addr;
      rf_data_d = gnt_data;
      if (gnt_idx == PTR_W'(REQUESTERS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + PTR_W'(1);
      end
    end

`ifdef CPU_REG_CLEAR_EN
    // cnt reaching SIZE marks the idle edge after the last clear write.
    if (state_q == ST_CLEAR) begin
      if (cnt_q == CNT_W'(SIZE)) begin
        state_d = ST_ARB;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end else begin
        rf_wr_d   = 1'b1;
        rf_addr_d = cnt_q[ADDRESS_BITS-1:0];
        rf_data_d = '0;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      ptr_q     <= '0;
    end else begin
      rf_wr_q   <= rf_wr_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      ptr_q     <= ptr_d;
    end
  end

`ifdef CPU_REG_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign rf_wr         = rf_wr_q;
  assign rf_addr_write = rf_addr_q;
  assign rf_data_write = rf_data_q;

endmodule

// File: tb/tb_cpu_reg_write_arbiter.sv
// Randomized bench for cpu_reg_write_arbiter against a queue-free round-robin reference model.
module tb_cpu_reg_write_arbiter;

  localparam int BITS = 8;
  localparam int SIZE = 16;
  localparam int R    = 3;
  localparam int AB   = $clog2(SIZE);

  logic              clk;
  logic              rst;
  logic              en;
  logic [R-1:0]      req_valid;
  logic [R*AB-1:0]   req_addr;
  logic [R*BITS-1:0] req_data;
  logic [R-1:0]      req_ready;
  logic              rf_wr;
  logic [AB-1:0]     rf_addr_write;
  logic [BITS-1:0]   rf_data_write;
  logic              busy;

  cpu_reg_write_arbiter #(.BITS(BITS), .SIZE(SIZE), .REQUESTERS(R)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_wr         (rf_wr),
    .rf_addr_write (rf_addr_write),
    .rf_data_write (rf_data_write),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: pending request per source, round-robin pointer, expected rf_* outputs.
  logic            pend [R];
  logic [AB-1:0]   paddr[R];
  logic [BITS-1:0] pdata[R];
  int              mptr;
  logic            exp_wr;
  logic [AB-1:0]   exp_addr;
  logic [BITS-1:0] exp_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < R; i++) begin
      req_valid[i]                = pend[i];
      req_addr[i*AB +: AB]        = paddr[i];
      req_data[i*BITS +: BITS]    = pdata[i];
    end
  endtask

  task automatic set_req(input int i, input logic [AB-1:0] a, input logic [BITS-1:0] d);
    pend[i]  = 1'b1;
    paddr[i] = a;
    pdata[i] = d;
  endtask

  function automatic int model_grant(input logic en_v);
    if (!en_v) return -1;
    for (int k = 0; k < R; k++) begin
      int i = (mptr + k) % R;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  // One arbitration cycle: new requests for idle sources in 'want', then grant and write checks.
  task automatic step(input logic [R-1:0] want, input logic en_v);
    int g;
    logic [R-1:0] exp_rdy;
    for (int i = 0; i < R; i++) begin
      if (!pend[i] && want[i]) begin
        set_req(i, AB'($urandom_range(0, 3)), BITS'($urandom));
      end
    end
    drive_inputs();
    en = en_v;
    #1;
    g = model_grant(en_v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      exp_wr   = 1'b1;
      exp_addr = paddr[g];
      exp_data = pdata[g];
      pend[g]  = 1'b0;
      mptr     = (g + 1) % R;
    end else begin
      exp_wr = 1'b0;
    end
    check_val("rf_wr", 32'(rf_wr), 32'(exp_wr));
    check_val("rf_addr_write", 32'(rf_addr_write), 32'(exp_addr));
    check_val("rf_data_write", 32'(rf_data_write), 32'(exp_data));
    check_val("busy_idle", 32'(busy), 32'd0);
  endtask

`ifdef CPU_REG_CLEAR_EN
  // Checks n clear edges; a full run also checks the trailing idle edge where busy falls.
  task automatic clear_seq(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_val("clr_wr", 32'(rf_wr), 32'd1);
      check_val("clr_addr", 32'(rf_addr_write), 32'(k));
      check_val("clr_data", 32'(rf_data_write), 32'd0);
      check_val("clr_busy", 32'(busy), 32'd1);
      check_val("clr_ready", 32'(req_ready), 32'd0);
    end
    if (n == SIZE) begin
      @(posedge clk);
      #1;
      check_val("clr_done_busy", 32'(busy), 32'd0);
      check_val("clr_done_wr", 32'(rf_wr), 32'd0);
      exp_wr   = 1'b0;
      exp_addr = AB'(SIZE - 1);
      exp_data = '0;
      mptr     = 0;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int guard;
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < R; i++) begin
      pend[i]  = 1'b0;
      paddr[i] = '0;
      pdata[i] = '0;
    end
    mptr     = 0;
    exp_wr   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    set_req(0, AB'(3), BITS'(8'h5A));
`ifdef CPU_REG_CLEAR_EN
    set_req(1, AB'(9), BITS'(8'h11));
    set_req(2, AB'(12), BITS'(8'h22));
`endif
    drive_inputs();

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_wr", 32'(rf_wr), 32'd0);
    check_val("rst_addr", 32'(rf_addr_write), 32'd0);
    check_val("rst_data", 32'(rf_data_write), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
`ifdef CPU_REG_CLEAR_EN
    check_val("rst_busy", 32'(busy), 32'd1);

    // Abort the clear at address 7 with an asynchronous reset, then run it fully.
    @(negedge clk);
    rst = 1'b0;
    clear_seq(8);
    #2;
    rst = 1'b1;
    #1;
    check_val("abort_wr", 32'(rf_wr), 32'd0);
    check_val("abort_addr", 32'(rf_addr_write), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    clear_seq(SIZE);
`else
    check_val("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif
    step('0, 1'b1);

    guard = 0;
    while ((pend[0] || pend[1] || pend[2]) && guard < 10) begin
      step('0, 1'b1);
      guard++;
    end
    check_val("drain", 32'(guard < 10), 32'd1);

    // Lone request from source 2, then a follow-up showing the pointer wrapped to 0.
    set_req(2, AB'(5), BITS'(8'hA5));
    step('0, 1'b1);
    check_val("src2_addr", 32'(rf_addr_write), 32'd5);
    check_val("src2_data", 32'(rf_data_write), 32'hA5);
    set_req(0, AB'(1), BITS'(8'h10));
    set_req(2, AB'(2), BITS'(8'h20));
    step('0, 1'b1);
    check_val("wrap_addr", 32'(rf_addr_write), 32'd1);
    step('0, 1'b1);

    // Enable held low with source 1 waiting, then released.
    set_req(1, AB'(7), BITS'(8'h77));
    repeat (3) step('0, 1'b0);
    step('0, 1'b1);
    check_val("en_release_data", 32'(rf_data_write), 32'h77);

    // All sources continuously valid: strict rotation, one write per cycle.
    repeat (6) step('1, 1'b1);

    for (int n = 0; n < 400; n++) begin
      step(R'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
